wb_arbiter: RTL

//   Writeback stage directly upstream of the register file's single write port (we/rd/wd).

---
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: the ALU result path, the LSU result path, the scoreboard
// claim and the register-file write port, grouped so they travel as one port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        sb_set;
    logic [4:0]  sb_rd;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    // Arbiter side of the bus
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  sb_set, sb_rd,
        output alu_stall, lsu_ready, busy_mask,
        output rf_we, rf_rd, rf_wd
    );

    // Producer / consumer side of the bus
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output sb_set, sb_rd,
        input  alu_stall, lsu_ready, busy_mask,
        input  rf_we, rf_rd, rf_wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered LSU results
// into one registered register-file write per cycle, with an anti-starvation stall
// for the LSU path and a scoreboard of outstanding long-latency destinations.
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_ALU,
        SEL_LSU
    } sel_t;

    logic [4:0]    r_fifoRd   [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_aluStall;
    logic          r_rfWe;
    logic          r_rfFromLsu;
    logic [4:0]    r_rfRd;
    logic [31:0]   r_rfWd;
    logic [31:0]   r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_aluReq;
    logic          w_push;
    logic          w_pop;
    logic          w_starveInc;
    logic          w_starveHit;
    sel_t          w_sel;
    logic [31:0]   w_busyNext;

    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_aluReq    = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign w_push      = bus.lsu_valid && !w_full && (bus.lsu_rd != 5'd0);
    assign w_pop       = (w_sel == SEL_LSU);
    assign w_starveInc = (w_sel == SEL_ALU) && !w_empty;
    assign w_starveHit = w_starveInc && (r_starve == SW'(STARVE_MAX - 1));

    assign bus.lsu_ready = !w_full;
    assign bus.alu_stall = r_aluStall;
    assign bus.rf_we     = r_rfWe;
    assign bus.rf_rd     = r_rfRd;
    assign bus.rf_wd     = r_rfWd;
    assign bus.busy_mask = r_busy;

    // Pick this cycle's writer: ALU unless stalled, else the FIFO head, else nothing
    always_comb begin
        w_sel = SEL_IDLE;
        if (!r_aluStall && w_aluReq) begin
            w_sel = SEL_ALU;
        end else if (!w_empty) begin
            w_sel = SEL_LSU;
        end
    end

    // Scoreboard update: retire the LSU write being latched now, then apply a new claim so set wins
    always_comb begin
        w_busyNext = r_busy;
        if (r_rfWe && r_rfFromLsu) begin
            w_busyNext[r_rfRd] = 1'b0;
        end
        if (bus.sb_set && (bus.sb_rd != 5'd0)) begin
            w_busyNext[bus.sb_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // FIFO storage; contents need no reset because the pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoRd[r_wrPtr]   <= bus.lsu_rd;
            r_fifoData[r_wrPtr] <= bus.lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Starvation tracking: count ALU wins over a waiting FIFO and raise a one-cycle stall at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve   <= '0;
            r_aluStall <= 1'b0;
        end else begin
            r_aluStall <= w_starveHit;
            if (w_starveInc && !w_starveHit) begin
                r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= '0;
            end
        end
    end

    // Register-file write port; address and data hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rfWe      <= 1'b0;
            r_rfFromLsu <= 1'b0;
            r_rfRd      <= 5'd0;
            r_rfWd      <= 32'd0;
        end else begin
            case (w_sel)
                SEL_ALU: begin
                    r_rfWe      <= 1'b1;
                    r_rfFromLsu <= 1'b0;
                    r_rfRd      <= bus.alu_rd;
                    r_rfWd      <= bus.alu_data;
                end
                SEL_LSU: begin
                    r_rfWe      <= 1'b1;
                    r_rfFromLsu <= 1'b1;
                    r_rfRd      <= r_fifoRd[r_rdPtr];
                    r_rfWd      <= r_fifoData[r_rdPtr];
                end
                default: begin
                    r_rfWe      <= 1'b0;
                    r_rfFromLsu <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busyNext;
        end
    end
endmodule
